// File: rtl/ls_addr_gen.sv
// Strided address generator / memory sequencer between the load/store unit and a single-port data memory.
// Optional stall counter: define LS_ADDR_GEN_STALL_CNT_EN to enable O_Stall_Cnt, otherwise it is tied to 0.
module ls_addr_gen #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_St_Req,
    input  logic                  I_Ld_Req,
    input  logic [ADDR_WIDTH-1:0] I_Length,
    input  logic [ADDR_WIDTH-1:0] I_Stride,
    input  logic [ADDR_WIDTH-1:0] I_Base_Addr,
    input  logic                  I_St_Valid,
    input  logic [DATA_WIDTH-1:0] I_St_Data,
    input  logic                  I_Ld_Valid,
    input  logic                  I_Mem_Stall,
    input  logic [DATA_WIDTH-1:0] I_Mem_RData,
    output logic                  O_St_Ready,
    output logic                  O_Ld_Ready,
    output logic [DATA_WIDTH-1:0] O_Ld_Data,
    output logic                  O_St_End_Access,
    output logic                  O_Ld_End_Access,
    output logic [ADDR_WIDTH-1:0] O_Mem_Addr,
    output logic                  O_Mem_We,
    output logic                  O_Mem_Re,
    output logic [DATA_WIDTH-1:0] O_Mem_WData,
    output logic                  O_Busy,
    output logic [15:0]           O_Stall_Cnt
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_RUN,
        S_LD_RUN,
        S_LD_DRAIN,
        S_END
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic                  r_is_store;
    logic                  r_ld_pend;
    logic                  w_accept;
    logic                  w_st_issue;
    logic                  w_ld_issue;
    logic                  w_issue;

    // Issue is suppressed while reset is high so an aborted access never touches memory.
    assign w_st_issue = (r_state == S_ST_RUN) && I_St_Valid && !I_Mem_Stall && !reset;
    assign w_ld_issue = (r_state == S_LD_RUN) && I_Ld_Valid && !I_Mem_Stall && !reset;
    assign w_issue    = w_st_issue || w_ld_issue;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_St_Req || I_Ld_Req) begin
                    w_accept = 1'b1;
                    if (I_Length == '0)
                        w_state_next = S_END;
                    else if (I_St_Req)
                        w_state_next = S_ST_RUN;
                    else
                        w_state_next = S_LD_RUN;
                end
            end
            S_ST_RUN: begin
                if (w_st_issue && (r_remaining == ONE))
                    w_state_next = S_END;
            end
            S_LD_RUN: begin
                if (w_ld_issue && (r_remaining == ONE))
                    w_state_next = S_LD_DRAIN;
            end
            S_LD_DRAIN: w_state_next = S_END;
            S_END:      w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
            r_is_store  <= 1'b0;
            r_ld_pend   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ld_pend <= w_ld_issue;
            if (w_accept) begin
                r_is_store  <= I_St_Req;
                r_stride    <= I_Stride;
                r_addr      <= I_Base_Addr;
                r_remaining <= I_Length;
            end else if (w_issue) begin
                r_addr      <= r_addr + r_stride;
                r_remaining <= r_remaining - ONE;
            end
        end
    end

    assign O_Mem_We        = w_st_issue;
    assign O_Mem_Re        = w_ld_issue;
    assign O_Mem_Addr      = w_issue ? r_addr : '0;
    assign O_Mem_WData     = w_st_issue ? I_St_Data : '0;
    assign O_St_Ready      = w_st_issue;
    // Memory returns read data one cycle after issue; forward it only in that cycle.
    assign O_Ld_Ready      = r_ld_pend;
    assign O_Ld_Data       = r_ld_pend ? I_Mem_RData : '0;
    assign O_St_End_Access = (r_state == S_END) && r_is_store;
    assign O_Ld_End_Access = (r_state == S_END) && !r_is_store;
    assign O_Busy          = (r_state != S_IDLE);

`ifdef LS_ADDR_GEN_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (((r_state == S_ST_RUN) || (r_state == S_LD_RUN)) && I_Mem_Stall
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign O_Stall_Cnt = r_stall_cnt;
`else
    assign O_Stall_Cnt = '0;
`endif

endmodule

// File: tb/tb_ls_addr_gen.sv
// Self-checking bench for ls_addr_gen: directed vector table, hand sequences and a
// randomized access model built from element index arithmetic (addr = base + k*stride).
module tb_ls_addr_gen;

`ifdef LS_ADDR_GEN_STALL_CNT_EN
    localparam int STALL_EN = 1;
`else
    localparam int STALL_EN = 0;
`endif

    logic        clock;
    logic        reset;
    logic        I_St_Req, I_Ld_Req;
    logic [15:0] I_Length, I_Stride, I_Base_Addr;
    logic        I_St_Valid, I_Ld_Valid, I_Mem_Stall;
    logic [31:0] I_St_Data, I_Mem_RData;
    logic        O_St_Ready, O_Ld_Ready;
    logic [31:0] O_Ld_Data;
    logic        O_St_End_Access, O_Ld_End_Access;
    logic [15:0] O_Mem_Addr;
    logic        O_Mem_We, O_Mem_Re;
    logic [31:0] O_Mem_WData;
    logic        O_Busy;
    logic [15:0] O_Stall_Cnt;

    ls_addr_gen #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .I_St_Req(I_St_Req), .I_Ld_Req(I_Ld_Req),
        .I_Length(I_Length), .I_Stride(I_Stride), .I_Base_Addr(I_Base_Addr),
        .I_St_Valid(I_St_Valid), .I_St_Data(I_St_Data),
        .I_Ld_Valid(I_Ld_Valid), .I_Mem_Stall(I_Mem_Stall), .I_Mem_RData(I_Mem_RData),
        .O_St_Ready(O_St_Ready), .O_Ld_Ready(O_Ld_Ready), .O_Ld_Data(O_Ld_Data),
        .O_St_End_Access(O_St_End_Access), .O_Ld_End_Access(O_Ld_End_Access),
        .O_Mem_Addr(O_Mem_Addr), .O_Mem_We(O_Mem_We), .O_Mem_Re(O_Mem_Re),
        .O_Mem_WData(O_Mem_WData), .O_Busy(O_Busy), .O_Stall_Cnt(O_Stall_Cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory emulation state: a read seen this cycle returns data next cycle.
    logic        rd_pend = 1'b0;
    logic [15:0] rd_addr = '0;

    typedef struct {
        logic        st_req, ld_req, st_v, ld_v, stall;
        logic [15:0] len, stride, base;
        logic [31:0] st_d;
        logic        e_we;
        logic [15:0] e_addr;
        logic        e_stend, e_ldend, e_busy;
        logic [15:0] e_scnt;
    } vec_t;

    function automatic logic [31:0] mem_f(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    function automatic vec_t mk(input logic sr, lr, sv, lv, st,
                                input logic [15:0] ln, sd, bs, input logic [31:0] d,
                                input logic we, input logic [15:0] ea,
                                input logic se, le, bz, input logic [15:0] sc);
        vec_t v;
        v.st_req = sr; v.ld_req = lr; v.st_v = sv; v.ld_v = lv; v.stall = st;
        v.len = ln; v.stride = sd; v.base = bs; v.st_d = d;
        v.e_we = we; v.e_addr = ea; v.e_stend = se; v.e_ldend = le; v.e_busy = bz; v.e_scnt = sc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then sample outputs 1 time unit later.
    task automatic drive_cycle(input logic rst, sr, lr, sv, lv, st, input logic [31:0] d,
                               input logic [15:0] ln, sd, bs);
        @(negedge clock);
        reset = rst; I_St_Req = sr; I_Ld_Req = lr; I_St_Valid = sv; I_Ld_Valid = lv;
        I_Mem_Stall = st; I_St_Data = d; I_Length = ln; I_Stride = sd; I_Base_Addr = bs;
        I_Mem_RData = rd_pend ? mem_f(rd_addr) : $urandom;
        #1;
        rd_pend = O_Mem_Re;
        rd_addr = O_Mem_Addr;
    endtask

    task automatic check_outputs(input string tag, input logic we, re, input logic [15:0] addr,
                                 input logic [31:0] wd, input logic srdy, lrdy,
                                 input logic [31:0] ldd, input logic se, le, bz);
        check($sformatf("%s mem", tag), {O_Mem_We, O_Mem_Re, O_Mem_Addr, O_Mem_WData}, {we, re, addr, wd});
        check($sformatf("%s rdy", tag), {O_St_Ready, O_Ld_Ready, O_Ld_Data}, {srdy, lrdy, ldd});
        check($sformatf("%s ctl", tag), {O_St_End_Access, O_Ld_End_Access, O_Busy}, {se, le, bz});
    endtask

    function automatic logic [15:0] exp_scnt(input int n);
        if (STALL_EN == 0) return 16'd0;
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    // One complete access against the element-index model; config inputs are scrambled mid-access.
    task automatic run_access(input bit is_st, input int len, input logic [15:0] stride, base,
                              input int v_pct, s_pct, input string tag);
        int          k = 0;
        int          stalls = 0;
        int          c = 0;
        bit          pend = 0;
        bit          valid, stall, issue, end_now;
        logic [15:0] pend_addr = '0;
        logic [15:0] a;
        logic [31:0] d;
        drive_cycle(0, is_st, !is_st, 0, 0, 0, 0, 16'(len), stride, base);
        check_outputs($sformatf("%s accept", tag), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        forever begin
            c++;
            valid   = ($urandom_range(99) < v_pct) || (c > 4 * len + 8);
            stall   = ($urandom_range(99) < s_pct) && (c <= 4 * len + 8);
            d       = $urandom;
            issue   = (k < len) && valid && !stall;
            a       = base + 16'(k) * stride;
            end_now = (k == len) && !pend;
            drive_cycle(0, is_st, !is_st, is_st && valid, !is_st && valid, stall, d,
                        16'($urandom), 16'($urandom), 16'($urandom));
            check_outputs($sformatf("%s c%0d", tag, c), is_st && issue, !is_st && issue,
                          issue ? a : 16'd0, (is_st && issue) ? d : 32'd0, is_st && issue,
                          pend, pend ? mem_f(pend_addr) : 32'd0,
                          end_now && is_st, end_now && !is_st, 1'b1);
            if (end_now) begin
                check($sformatf("%s stall_cnt", tag), O_Stall_Cnt, exp_scnt(stalls));
                break;
            end
            if (stall && (k < len)) stalls++;
            pend      = !is_st && issue;
            pend_addr = a;
            if (issue) k++;
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_outputs($sformatf("%s idle", tag), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[18];
        //            sr lr sv lv st len    stride base    data            we addr    se le bz scnt
        vt[0]  = mk(1, 0, 0, 0, 0, 16'd4, 16'd2, 16'h10, 32'h0,         0, 16'h0,  0, 0, 0, 0);
        vt[1]  = mk(1, 0, 1, 0, 0, 16'd9, 16'd7, 16'h80, 32'h11110000,  1, 16'h10, 0, 0, 1, 0);
        vt[2]  = mk(1, 0, 1, 0, 0, 16'd9, 16'd7, 16'h80, 32'h11110001,  1, 16'h12, 0, 0, 1, 0);
        vt[3]  = mk(1, 0, 1, 0, 0, 16'd9, 16'd7, 16'h80, 32'h11110002,  1, 16'h14, 0, 0, 1, 0);
        vt[4]  = mk(1, 0, 1, 0, 0, 16'd9, 16'd7, 16'h80, 32'h11110003,  1, 16'h16, 0, 0, 1, 0);
        vt[5]  = mk(1, 0, 1, 0, 0, 16'd9, 16'd7, 16'h80, 32'h11110004,  0, 16'h0,  1, 0, 1, 0);
        vt[6]  = mk(0, 0, 0, 0, 0, 16'd0, 16'd0, 16'h0,  32'h0,         0, 16'h0,  0, 0, 0, 0);
        vt[7]  = mk(1, 0, 0, 0, 0, 16'd3, 16'd1, 16'h20, 32'h0,         0, 16'h0,  0, 0, 0, 0);
        vt[8]  = mk(1, 0, 1, 0, 0, 16'd3, 16'd5, 16'h99, 32'h22220000,  1, 16'h20, 0, 0, 1, 0);
        vt[9]  = mk(1, 0, 1, 0, 1, 16'd3, 16'd5, 16'h99, 32'h22220001,  0, 16'h0,  0, 0, 1, 0);
        vt[10] = mk(1, 0, 1, 0, 1, 16'd3, 16'd5, 16'h99, 32'h22220001,  0, 16'h0,  0, 0, 1, 1);
        vt[11] = mk(1, 0, 1, 0, 0, 16'd3, 16'd5, 16'h99, 32'h22220001,  1, 16'h21, 0, 0, 1, 2);
        vt[12] = mk(1, 0, 1, 0, 0, 16'd3, 16'd5, 16'h99, 32'h22220002,  1, 16'h22, 0, 0, 1, 2);
        vt[13] = mk(1, 0, 1, 0, 0, 16'd3, 16'd5, 16'h99, 32'h22220003,  0, 16'h0,  1, 0, 1, 2);
        vt[14] = mk(0, 0, 0, 0, 0, 16'd0, 16'd0, 16'h0,  32'h0,         0, 16'h0,  0, 0, 0, 2);
        vt[15] = mk(1, 1, 1, 1, 0, 16'd0, 16'd1, 16'h55, 32'hABCD,      0, 16'h0,  0, 0, 0, 2);
        vt[16] = mk(1, 1, 1, 1, 0, 16'd0, 16'd1, 16'h55, 32'hABCD,      0, 16'h0,  1, 0, 1, 0);
        vt[17] = mk(0, 0, 0, 0, 0, 16'd0, 16'd0, 16'h0,  32'h0,         0, 16'h0,  0, 0, 0, 0);

        reset = 1'b1; I_St_Req = 0; I_Ld_Req = 0; I_Length = 0; I_Stride = 0; I_Base_Addr = 0;
        I_St_Valid = 0; I_St_Data = 0; I_Ld_Valid = 0; I_Mem_Stall = 0; I_Mem_RData = 0;
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset stall_cnt", O_Stall_Cnt, 16'd0);

        for (int i = 0; i < 18; i++) begin
            drive_cycle(0, vt[i].st_req, vt[i].ld_req, vt[i].st_v, vt[i].ld_v, vt[i].stall,
                        vt[i].st_d, vt[i].len, vt[i].stride, vt[i].base);
            check_outputs($sformatf("vec%0d", i), vt[i].e_we, 1'b0, vt[i].e_addr,
                          vt[i].e_we ? vt[i].st_d : 32'd0, vt[i].e_we, 1'b0, 32'd0,
                          vt[i].e_stend, vt[i].e_ldend, vt[i].e_busy);
            check($sformatf("vec%0d stall_cnt", i), O_Stall_Cnt, exp_scnt(int'(vt[i].e_scnt)));
        end

        run_access(0, 3, 16'd1, 16'hFFFE, 100, 0, "ld_wrap");

        // Reset in the middle of a 5-element load, after two reads.
        drive_cycle(0, 0, 1, 0, 0, 0, 0, 16'd5, 16'd3, 16'h100);
        check_outputs("rstld accept", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 1, 0, 1, 0, 0, 16'd5, 16'd3, 16'h100);
        check_outputs("rstld rd0", 0, 1, 16'h100, 0, 0, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 1, 0, 1, 0, 0, 16'd5, 16'd3, 16'h100);
        check_outputs("rstld rd1", 0, 1, 16'h103, 0, 0, 1, mem_f(16'h100), 0, 0, 1);
        drive_cycle(1, 0, 1, 0, 0, 0, 0, 16'd5, 16'd3, 16'h100);
        check_outputs("rstld rst", 0, 0, 0, 0, 0, 1, mem_f(16'h103), 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            check_outputs($sformatf("rstld post%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            check($sformatf("rstld post%0d stall_cnt", i), O_Stall_Cnt, 16'd0);
        end
        run_access(0, 3, 16'd4, 16'h200, 100, 0, "ld_after_rst");

        for (int i = 0; i < 30; i++) begin
            run_access(bit'($urandom_range(1)), int'($urandom_range(12)),
                       ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(8)),
                       16'($urandom), int'($urandom_range(100, 60)), int'($urandom_range(40)),
                       $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ls_addr_gen.md
# ls_addr_gen

Strided address generator and memory sequencer sitting directly downstream of the TPU load/store unit, between it and the local data memory. Accepts one vector load or store request at a time, latches length/stride/base, walks the addresses one element per cycle, moves data between the load/store unit and a single-port memory, and signals per-element readiness and end of access back upstream.

## Interface
- ADDR_WIDTH, 16, width of length, stride, base and memory address
- DATA_WIDTH, 32, element data width
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- I_St_Req  in  1  store request level, held until end of access
- I_Ld_Req  in  1  load request level, held until end of access
- I_Length  in  ADDR_WIDTH  element count
- I_Stride  in  ADDR_WIDTH  address increment per element, unsigned, modulo 2^ADDR_WIDTH
- I_Base_Addr  in  ADDR_WIDTH  first element address
- I_St_Valid  in  1  store data presented
- I_St_Data  in  DATA_WIDTH  store data
- I_Ld_Valid  in  1  load element requested
- I_Mem_Stall  in  1  memory busy; blocks new issue
- I_Mem_RData  in  DATA_WIDTH  memory read data, one cycle after read issue
- O_St_Ready  out  1  store element accepted this cycle
- O_Ld_Ready  out  1  load data valid on O_Ld_Data this cycle
- O_Ld_Data  out  DATA_WIDTH  load data
- O_St_End_Access  out  1  one-cycle pulse, store finished
- O_Ld_End_Access  out  1  one-cycle pulse, load finished
- O_Mem_Addr  out  ADDR_WIDTH  memory address
- O_Mem_We  out  1  memory write enable
- O_Mem_Re  out  1  memory read enable
- O_Mem_WData  out  DATA_WIDTH  memory write data
- O_Busy  out  1  state != IDLE
- O_Stall_Cnt  out  16  stall counter (see Configuration)

## Operation
- States: IDLE, ST_RUN, LD_RUN, LD_DRAIN, END.
- IDLE: on I_St_Req latch length/stride/base, remaining=I_Length, addr=I_Base_Addr, go ST_RUN; else on I_Ld_Req same, go LD_RUN. Both asserted: store wins. Length 0: go straight to END, no memory access.
- ST_RUN: issue when I_St_Valid & ~I_Mem_Stall: O_St_Ready=1, O_Mem_We=1, O_Mem_Addr=addr, O_Mem_WData=I_St_Data (combinational); addr+=stride, remaining-=1. Issue with remaining==1 -> END.
- LD_RUN: issue when I_Ld_Valid & ~I_Mem_Stall: O_Mem_Re=1, O_Mem_Addr=addr; addr+=stride, remaining-=1. Registered flag makes O_Ld_Ready=1 next cycle with O_Ld_Data=I_Mem_RData. Last issue -> LD_DRAIN.
- LD_DRAIN: last O_Ld_Ready asserted; -> END.
- END: O_St_End_Access or O_Ld_End_Access (per latched type) =1 for exactly one cycle; -> IDLE. Requests ignored in END.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no fault.
- Latched config stable for whole access; input changes mid-access ignored.
- O_Mem_We/O_Mem_Re never both 1; O_Mem_Addr=0 when neither asserted.

## Timing
- Reset: state IDLE, all outputs 0, counters/latches 0; reset mid-access aborts with no end pulse and no further memory access.
- Throughput one element/cycle when valid and not stalled.
- Store: write in accept cycle; end pulse the cycle after last accept. Length N, no stalls: end pulse N cycles after first accept cycle... i.e. cycle N+1 after leaving IDLE.
- Load: read latency 1; data return independent of I_Mem_Stall; end pulse one cycle after last O_Ld_Ready.
- I_Mem_Stall only blocks issue; held indefinitely holds state and addr.

## Configuration
- LS_ADDR_GEN_STALL_CNT_EN defined: O_Stall_Cnt counts cycles in ST_RUN/LD_RUN with I_Mem_Stall=1, saturates at 0xFFFF, clears to 0 on request acceptance in IDLE, holds value otherwise.
- Not defined: counter absent, O_Stall_Cnt tied to 0.

## Test plan
- Store length 4, base 0x10, stride 2, valid every cycle -> writes at 0x10,0x12,0x14,0x16 with O_St_Ready each cycle, O_St_End_Access one cycle after last write.
- Load length 3, base 0xFFFE, stride 1 -> reads 0xFFFE,0xFFFF,0x0000; O_Ld_Ready one cycle after each read with memory data; end pulse after last ready.
- Store length 3 with I_Mem_Stall high 2 cycles mid-stream -> no write during stall, addresses continue correctly, counter=2 when macro defined, 0 otherwise.
- I_St_Req and I_Ld_Req together, length 0 -> store chosen, no memory access, O_St_End_Access pulse in next cycle, O_Ld_End_Access stays 0.
- Reset asserted during load after 2 of 5 reads -> all outputs 0 next cycle, no end pulse; new load then runs from its own base.
